// File: rtl/shift_left.sv
// Combinational lane shifter: moves whole lanes toward the MSB and fills vacated lanes.
// Shifts above MAX_STEP are flagged invalid through valid_o.
module shift_left #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned LANE_W   = 12,
  parameter int unsigned MAX_STEP = 5
) (
  input  logic [LANES*LANE_W-1:0] data_i,
  input  logic [2:0]              shift_i,
  input  logic [LANE_W-1:0]       fill_i,
  output logic [LANES*LANE_W-1:0] data_o,
  output logic                    valid_o
);

  always_comb begin
    data_o  = '0;
    valid_o = (shift_i <= 3'(MAX_STEP));
    for (int k = 0; k < int'(LANES); k++) begin
      if (k < int'(shift_i)) begin
        data_o[k*LANE_W +: LANE_W] = fill_i;
      end else begin
        data_o[k*LANE_W +: LANE_W] = data_i[(k - int'(shift_i))*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// Handshaked sequencer around shift_left; shifts above MAX_STEP run as two passes.
// Optional counters (pass_cnt, sat_cnt) are enabled by defining SHIFT_LEFT_SEQ_STATS_EN.
module shift_left_seq #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned LANE_W   = 12,
  parameter int unsigned MAX_STEP = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [3:0]              in_shift,
  input  logic [LANE_W-1:0]       in_fill,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_err
`ifdef SHIFT_LEFT_SEQ_STATS_EN
  ,
  output logic [15:0]             pass_cnt,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int unsigned DataW = LANES * LANE_W;

  typedef enum logic [1:0] {StIdle, StPass, StDone} state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   data_q, data_d;
  logic [DataW-1:0]   out_data_q, out_data_d;
  logic [LANE_W-1:0]  fill_q, fill_d;
  logic [3:0]         rem_q, rem_d;
  logic               err_q, err_d;
  logic [2:0]         step;
  logic [DataW-1:0]   shifter_out;
  logic               shifter_valid;
  logic               in_pass;
  logic               accept;

  assign in_pass  = (state_q == StPass);
  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = in_valid && in_ready;
  assign step     = (rem_q > 4'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];

  shift_left #(
    .LANES   (LANES),
    .LANE_W  (LANE_W),
    .MAX_STEP(MAX_STEP)
  ) u_shifter (
    .data_i (data_q),
    .shift_i(step),
    .fill_i (fill_q),
    .data_o (shifter_out),
    .valid_o(shifter_valid)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    fill_d     = fill_q;
    rem_d      = rem_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = in_data;
          fill_d  = in_fill;
          // Shifts past the word width saturate: every lane becomes fill.
          rem_d   = (in_shift > 4'(LANES)) ? 4'(LANES) : in_shift;
          err_d   = (in_shift > 4'(LANES));
          state_d = StPass;
        end
      end
      StPass: begin
        if (shifter_valid) begin
          data_d = shifter_out;
          rem_d  = rem_q - {1'b0, step};
          if (rem_d == 4'd0) begin
            out_data_d = shifter_out;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      out_data_q <= '0;
      fill_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      fill_q     <= fill_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign out_err   = out_valid && err_q;
  assign out_data  = out_data_q;

`ifdef SHIFT_LEFT_SEQ_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    sat_cnt_d  = sat_cnt_q;
    if (in_pass && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_d = pass_cnt_q + 16'd1;
    end
    if (accept && (in_shift > 4'(LANES)) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign sat_cnt  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: driver pushes model results, negedge monitor pops.
module tb_shift_left_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [3:0]  in_shift;
  logic [11:0] in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic        out_err;
`ifdef SHIFT_LEFT_SEQ_STATS_EN
  logic [15:0] pass_cnt;
  logic [15:0] sat_cnt;
`endif

  shift_left_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .in_fill  (in_fill),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
`ifdef SHIFT_LEFT_SEQ_STATS_EN
    ,
    .pass_cnt (pass_cnt),
    .sat_cnt  (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise = 0;
  logic prev_v = 1'b0;
  logic hs_prev = 1'b0;
  logic rand_ready = 1'b0;
  logic ready_force = 1'b1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: view the word as 8 lanes, slide them up by min(shift,8), pad with fill.
  function automatic logic [95:0] model(input logic [95:0] d, input int sh, input logic [11:0] f);
    logic [11:0] lanes[8];
    logic [95:0] r;
    int s;
    s = (sh > 8) ? 8 : sh;
    for (int k = 0; k < 8; k++) lanes[k] = d[k*12 +: 12];
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < s) r[k*12 +: 12] = f;
      else r[k*12 +: 12] = lanes[k-s];
    end
    return r;
  endfunction

  function automatic int sat_shift(input int sh);
    return (sh > 8) ? 8 : sh;
  endfunction

  task automatic send(input logic [95:0] d, input int sh, input logic [11:0] f);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 4'(sh);
    in_fill  = f;
    e.data = model(d, sh, f);
    e.err  = (sh > 8);
    e.lat  = (sat_shift(sh) <= 5) ? 1 : 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
    in_shift = 4'($urandom_range(0, 15));
    in_fill  = 12'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
    end
  endtask

  // Consumer backpressure, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) begin
      acc_cyc.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (dut.in_pass) chk("shifter_valid_in_pass", 96'(dut.shifter_valid), 96'd1);
      if (hs_prev) chk("ready_after_hs", 96'(in_ready), 96'd1);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (!prev_v) rise = cyc;
        if (sb.size() == 0 || acc_cyc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=out_valid required=no_pending");
        end else begin
          chk("out_data", out_data, sb[0].data);
          chk("out_err", 96'(out_err), 96'(sb[0].err));
          chk("in_ready_busy", 96'(in_ready), 96'd0);
          if (out_ready) begin
            chk("latency", 96'(rise - acc_cyc[0]), 96'(sb[0].lat));
            void'(sb.pop_front());
            void'(acc_cyc.pop_front());
            hs_prev = 1'b1;
          end
        end
      end
      prev_v = out_valid;
    end
  end

  logic [95:0] ramp;
  int          b2b_sh[7] = '{1, 6, 0, 8, 5, 7, 3};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_shift = '0;
    in_fill  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) ramp[k*12 +: 12] = 12'(k);

    #12;
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out_data", out_data, 96'd0);
    chk("rst_out_err", 96'(out_err), 96'd0);
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the plan.
    ready_force = 1'b1;
    send(ramp, 2, 12'hABC);
    send(ramp, 7, 12'h111);
    send(ramp, 8, 12'h5A5);
    send(ramp, 12, 12'h5A5);
    drain();

    // Shift 0 held under backpressure.
    ready_force = 1'b0;
    @(negedge clk);
    send(ramp, 0, 12'hFFF);
    repeat (10) @(negedge clk);
    chk("hold_out_valid", 96'(out_valid), 96'd1);
    chk("hold_in_ready", 96'(in_ready), 96'd0);
    chk("hold_out_data", out_data, ramp);
    ready_force = 1'b1;
    drain();

    // Back-to-back throughput.
    acc_log.delete();
    foreach (b2b_sh[i]) send({$urandom, $urandom, $urandom}, b2b_sh[i], 12'($urandom));
    drain();
    checks++;
    if (acc_log.size() != 7) begin
      errors++;
      $display("FAIL b2b_count actual=%0d required=7", acc_log.size());
    end else begin
      for (int i = 0; i < 6; i++)
        chk("b2b_interval", 96'(acc_log[i+1] - acc_log[i]), 96'((b2b_sh[i] >= 6) ? 4 : 3));
    end

    // Reset during the second pass of a shift-6 request.
    send(ramp, 6, 12'h777);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 96'(out_valid), 96'd0);
    chk("abort_out_data", out_data, 96'd0);
    chk("abort_in_ready", 96'(in_ready), 96'd0);
    sb.delete();
    acc_cyc.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(ramp, 1, 12'h246);
    drain();

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++)
      send({$urandom, $urandom, $urandom}, $urandom_range(0, 15), 12'($urandom));
    drain();
    rand_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
